pipelined_datapath: RTL

//  Parametrised two-stage register-file + ALU datapath: EX (operand latch) then WB (result latch, RF write).

---
 rtl/pipelined_datapath.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipelined_datapath.sv
// Two-stage register-file + ALU datapath: EX latches operands, WB latches the result and writes the RF.
// Valid/ready instruction and result streams, with EX->operand forwarding so dependent instructions issue back-to-back.
module pipelined_datapath #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_imm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_carry,
    output logic              res_ovf,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int unsigned MSB    = DATA_W - 1;
    localparam logic [2:0]  OP_ADD = 3'd0;
    localparam logic [2:0]  OP_SUB = 3'd1;
    localparam logic [2:0]  OP_AND = 3'd2;
    localparam logic [2:0]  OP_OR  = 3'd3;
    localparam logic [2:0]  OP_XOR = 3'd4;
    localparam logic [2:0]  OP_SLT = 3'd5;
    localparam logic [2:0]  OP_LDI = 3'd6;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic              ex_valid;
    logic [2:0]        ex_op;
    logic [ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;

    logic              ex_adv;
    logic              accept;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_ovf;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign ex_adv   = ex_valid & (~res_valid | res_ready);
    assign in_ready = ~ex_valid | ex_adv;
    assign accept   = in_valid & in_ready;
    assign dbg_data = is_zero_reg(dbg_addr) ? '0 : rf[dbg_addr];

    // ALU on the EX operands; SUB carry is the borrow-free flag (A >= B unsigned)
    always_comb begin
        sum_ext   = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (ex_op)
            OP_ADD: begin
                sum_ext   = {1'b0, ex_a} + {1'b0, ex_b};
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = (ex_a[MSB] == ex_b[MSB]) && (alu_res[MSB] != ex_a[MSB]);
            end
            OP_SUB: begin
                sum_ext   = {1'b0, ex_a} + {1'b0, ~ex_b} + (DATA_W+1)'(1);
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = (ex_a[MSB] != ex_b[MSB]) && (alu_res[MSB] != ex_a[MSB]);
            end
            OP_AND: alu_res = ex_a & ex_b;
            OP_OR:  alu_res = ex_a | ex_b;
            OP_XOR: alu_res = ex_a ^ ex_b;
            OP_SLT: alu_res[0] = ($signed(ex_a) < $signed(ex_b));
            OP_LDI: alu_res = ex_imm;
            default: alu_res = ex_a;
        endcase
    end

    // Operand select: the EX result overrides the RF, which is only written as EX retires
    always_comb begin
        opnd_a = rf[in_rs1];
        opnd_b = rf[in_rs2];
        if (is_zero_reg(in_rs1)) begin
            opnd_a = '0;
        end else if (ex_valid && (ex_rd == in_rs1)) begin
            opnd_a = alu_res;
        end
        if (is_zero_reg(in_rs2)) begin
            opnd_b = '0;
        end else if (ex_valid && (ex_rd == in_rs2)) begin
            opnd_b = alu_res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_op    <= in_op;
            ex_rd    <= in_rd;
            ex_a     <= opnd_a;
            ex_b     <= opnd_b;
            ex_imm   <= in_imm;
        end else if (ex_adv) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
        end else if (ex_adv) begin
            res_valid <= 1'b1;
            res_rd    <= ex_rd;
            res_data  <= alu_res;
            res_zero  <= (alu_res == '0);
            res_carry <= alu_carry;
            res_ovf   <= alu_ovf;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (ex_adv && !is_zero_reg(ex_rd)) begin
            rf[ex_rd] <= alu_res;
        end
    end

endmodule
